// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch path: colour type,
// sprite geometry, transparent colour key and the read-pipeline tag.
package sprite_pkg;

  localparam int DATA_W       = 9;
  localparam int SPRITE_SIZE  = 20;
  localparam int SPRITE_WORDS = SPRITE_SIZE * SPRITE_SIZE;

  typedef logic [DATA_W-1:0] color_t;

  localparam color_t TRANSP_COLOR = 9'h1FF;

  typedef struct packed {
    logic valid;
    logic oob;
  } tag_t;

endpackage

// File: rtl/sprite_resp_fifo.sv
// Synchronous response FIFO; the head is forced to zero while empty and
// the occupancy count feeds the read-credit check in the fetch unit.
module sprite_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sprite_fetch_unit.sv
// Sprite memory master: arbitrates processor writes against pixel reads and
// returns colours in request order. Optional mirroring: SPRITE_FETCH_HFLIP_EN.
module sprite_fetch_unit
  import sprite_pkg::*;
#(
  parameter int                    ADDR_W       = 14,
  parameter int                    DATA_W       = sprite_pkg::DATA_W,
  parameter int                    SPRITE_SIZE  = sprite_pkg::SPRITE_SIZE,
  parameter int                    OFFSET_W     = 6,
  parameter int                    COORD_W      = 5,
  parameter int                    RD_LATENCY   = 1,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [DATA_W-1:0]     TRANSP_COLOR = sprite_pkg::TRANSP_COLOR
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OFFSET_W-1:0] req_offset,
  input  logic [COORD_W-1:0]  req_x,
  input  logic [COORD_W-1:0]  req_y,
`ifdef SPRITE_FETCH_HFLIP_EN
  input  logic                req_hflip,
`endif
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_q,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [DATA_W-1:0]   pix_data,
  output logic                pix_transparent,
  output logic                pix_oob
);

  localparam int STAGES  = RD_LATENCY + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + 2;

  logic [31:0]        eff_x;
  logic [31:0]        addr_full;
  logic               rd_oob;
  tag_t               tag_sr [STAGES];
  int unsigned        inflight;
  int unsigned        credits;
  logic [CNT_W-1:0]   fifo_count;
  logic               rd_elig;
  logic               grant_wr;
  logic               grant_rd;
  logic               prio_wr;
  tag_t               cap;
  logic               cap_transp;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    eff_x = 32'(req_x);
`ifdef SPRITE_FETCH_HFLIP_EN
    if (req_hflip) eff_x = 32'(SPRITE_SIZE - 1) - 32'(req_x);
`endif
    addr_full = 32'(req_offset) * 32'(SPRITE_SIZE * SPRITE_SIZE)
              + 32'(req_y) * 32'(SPRITE_SIZE) + eff_x;
    // Range test uses the unmirrored x so a flipped request cannot wrap into range.
    rd_oob = (32'(req_x) >= 32'(SPRITE_SIZE)) || (32'(req_y) >= 32'(SPRITE_SIZE))
          || (addr_full >= (32'd1 << ADDR_W));
  end

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      inflight = inflight + 32'(tag_sr[i].valid);
    end
    credits  = inflight + 32'(fifo_count);
    rd_elig  = req_valid && (credits < 32'(FIFO_DEPTH));
    grant_wr = wr_valid && (!rd_elig || prio_wr);
    grant_rd = rd_elig && (!wr_valid || !prio_wr);
  end

  assign wr_ready  = reset_n && grant_wr;
  assign req_ready = reset_n && grant_rd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      prio_wr     <= 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) tag_sr[i] <= '0;
    end else begin
      mem_wren  <= grant_wr;
      tag_sr[0] <= '{valid: grant_rd, oob: grant_rd && rd_oob};
      for (int unsigned i = 1; i < STAGES; i++) tag_sr[i] <= tag_sr[i-1];
      if (grant_wr) begin
        mem_address <= wr_address;
        mem_data    <= wr_data;
        prio_wr     <= 1'b0;
      end else if (grant_rd) begin
        prio_wr <= 1'b1;
        if (!rd_oob) mem_address <= addr_full[ADDR_W-1:0];
      end
    end
  end

  assign cap        = tag_sr[STAGES-1];
  assign cap_transp = cap.oob || (mem_q == TRANSP_COLOR);
  assign push_data  = {cap.oob, cap_transp, cap.oob ? {DATA_W{1'b0}} : mem_q};

  sprite_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (cap.valid),
    .push_data (push_data),
    .pop       (pix_ready),
    .head      (head),
    .valid     (pix_valid),
    .count     (fifo_count)
  );

  assign pix_oob         = head[ENTRY_W-1];
  assign pix_transparent = head[ENTRY_W-2];
  assign pix_data        = head[DATA_W-1:0];

endmodule

// File: tb/tb_sprite_fetch_unit.sv
// Directed bench for sprite_fetch_unit with a behavioural sprite memory
// and a scoreboard of expected pixel responses in request order.
module tb_sprite_fetch_unit;

  logic       clock;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_offset;
  logic [4:0] req_x;
  logic [4:0] req_y;
  logic       wr_valid;
  logic       wr_ready;
  logic [13:0] wr_address;
  logic [8:0] wr_data;
  logic [13:0] mem_address;
  logic [8:0] mem_data;
  logic       mem_wren;
  logic [8:0] mem_q;
  logic       pix_valid;
  logic       pix_ready;
  logic [8:0] pix_data;
  logic       pix_transparent;
  logic       pix_oob;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       oob;
    logic       tr;
    logic [8:0] d;
  } exp_t;

  exp_t sb [$];

  bit         wflag [16384];
  logic [8:0] wmem  [16384];
  bit         gflag [16384];
  logic [8:0] gmem  [16384];

  sprite_fetch_unit #(
    .ADDR_W     (14),
    .DATA_W     (9),
    .SPRITE_SIZE(20),
    .OFFSET_W   (6),
    .COORD_W    (5),
    .RD_LATENCY (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_offset     (req_offset),
    .req_x          (req_x),
    .req_y          (req_y),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .pix_transparent(pix_transparent),
    .pix_oob        (pix_oob)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [8:0] init_val(input int a);
    return 9'((a * 37) % 511);
  endfunction

  // Single-port synchronous memory, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_wren) begin
      wmem[mem_address]  <= mem_data;
      wflag[mem_address] <= 1'b1;
    end
    mem_q <= wflag[mem_address] ? wmem[mem_address] : init_val(int'(mem_address));
  end

  function automatic logic [8:0] golden(input int a);
    return gflag[a] ? gmem[a] : init_val(a);
  endfunction

  function automatic exp_t exp_of(input int off, input int x, input int y);
    exp_t e;
    int   a;
    a     = off * 400 + y * 20 + x;
    e.oob = (x >= 20) || (y >= 20) || (a >= 16384);
    e.d   = e.oob ? 9'd0 : golden(a);
    e.tr  = e.oob || (e.d == 9'h1FF);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && pix_valid && pix_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pix", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pix_data", 32'(pix_data), 32'(e.d));
        check("pix_transparent", 32'(pix_transparent), 32'(e.tr));
        check("pix_oob", 32'(pix_oob), 32'(e.oob));
      end
    end
  end

  // Leaves req_valid asserted; caller decides whether to drop it.
  task automatic issue(input int off, input int x, input int y, output int waited);
    bit acc;
    acc        = 1'b0;
    waited     = 0;
    req_valid  = 1'b1;
    req_offset = 6'(off);
    req_x      = 5'(x);
    req_y      = 5'(y);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      waited++;
      if (req_ready) begin
        acc = 1'b1;
        sb.push_back(exp_of(off, x, y));
      end
      @(posedge clock);
      #1;
      if (acc) break;
    end
    check("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic do_write(input int addr, input logic [8:0] data);
    bit acc;
    acc        = 1'b0;
    wr_valid   = 1'b1;
    wr_address = 14'(addr);
    wr_data    = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (wr_ready) acc = 1'b1;
      @(posedge clock);
      #1;
      if (acc) break;
    end
    wr_valid = 1'b0;
    check("wr_accept", 32'(acc), 32'd1);
    gflag[addr] = 1'b1;
    gmem[addr]  = data;
    check("wr_wren", 32'(mem_wren), 32'd1);
    check("wr_address", 32'(mem_address), 32'(addr));
    check("wr_data", 32'(mem_data), 32'(data));
    @(posedge clock);
    #1;
    check("wr_wren_pulse", 32'(mem_wren), 32'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clock);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w;
    int total;
    int acc_cnt;
    bit last_ready;
    int wren_cnt;
    int rd_cnt;

    reset_n    = 1'b0;
    req_valid  = 1'b1;
    wr_valid   = 1'b1;
    pix_ready  = 1'b1;
    req_offset = '0;
    req_x      = '0;
    req_y      = '0;
    wr_address = '0;
    wr_data    = '0;
    #3;
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_flags", {pix_data, pix_transparent, pix_oob}, 32'd0);
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    #9 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic write then read with latency check.
    do_write(823, 9'h0A5);
    issue(2, 3, 1, w);
    req_valid = 1'b0;
    check("t1_mem_address", 32'(mem_address), 32'd823);
    check("t1_mem_wren", 32'(mem_wren), 32'd0);
    @(posedge clock);
    #1;
    check("t1_pix_valid_early", 32'(pix_valid), 32'd0);
    @(posedge clock);
    #1;
    check("t1_pix_valid_lat", 32'(pix_valid), 32'd1);
    wait_drain();

    // Transparent colour key.
    do_write(0, 9'h1FF);
    issue(0, 0, 0, w);
    req_valid = 1'b0;
    wait_drain();

    // Out-of-range requests interleaved with in-range neighbours.
    issue(1, 5, 5, w);
    issue(0, 20, 0, w);
    check("t3_oob_x_addr", 32'(mem_address), 32'd505);
    check("t3_oob_x_wren", 32'(mem_wren), 32'd0);
    issue(0, 0, 25, w);
    check("t3_oob_y_addr", 32'(mem_address), 32'd505);
    issue(40, 3, 19, w);
    check("t3_max_addr", 32'(mem_address), 32'd16383);
    issue(40, 4, 19, w);
    check("t3_oob_addr_hold", 32'(mem_address), 32'd16383);
    issue(63, 0, 0, w);
    issue(3, 19, 19, w);
    req_valid = 1'b0;
    wait_drain();

    // Backpressure: credits limit acceptance to the FIFO depth.
    pix_ready  = 1'b0;
    acc_cnt    = 0;
    last_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid  = 1'b1;
      req_offset = 6'd4;
      req_x      = 5'(i);
      req_y      = 5'(i + 1);
      @(negedge clock);
      last_ready = req_ready;
      if (req_ready) begin
        acc_cnt++;
        sb.push_back(exp_of(4, i, i + 1));
      end
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    check("t4_accepted", 32'(acc_cnt), 32'd4);
    check("t4_ready_low", 32'(last_ready), 32'd0);
    check("t4_head_stable", 32'(pix_valid), 32'd1);
    pix_ready = 1'b1;
    wait_drain();
    total = 0;
    for (int i = 0; i < 8; i++) begin
      issue(5, i, 2 * i, w);
      total += w;
    end
    req_valid = 1'b0;
    check("t4_stream_cycles", 32'(total), 32'd8);
    wait_drain();

    // Contention: grants alternate, starting with the write after reads.
    wren_cnt   = 0;
    rd_cnt     = 0;
    req_offset = 6'd1;
    req_x      = 5'd2;
    req_y      = 5'd3;
    for (int i = 0; i < 8; i++) begin
      wr_valid   = 1'b1;
      wr_address = 14'(5000 + i);
      wr_data    = 9'(i * 3 + 1);
      req_valid  = 1'b1;
      @(negedge clock);
      check("t5_one_grant", 32'(wr_ready & req_ready), 32'd0);
      check("t5_grant_wr", 32'(wr_ready), 32'((i % 2) == 0));
      check("t5_grant_rd", 32'(req_ready), 32'((i % 2) == 1));
      if (wr_ready) begin
        gflag[5000 + i] = 1'b1;
        gmem[5000 + i]  = 9'(i * 3 + 1);
      end
      if (req_ready) begin
        rd_cnt++;
        sb.push_back(exp_of(1, 2, 3));
      end
      @(posedge clock);
      #1;
      if (mem_wren) wren_cnt++;
    end
    wr_valid  = 1'b0;
    req_valid = 1'b0;
    check("t5_wren_pulses", 32'(wren_cnt), 32'd4);
    check("t5_reads", 32'(rd_cnt), 32'd4);
    wait_drain();

    // Reset with two reads in flight.
    issue(2, 3, 1, w);
    issue(1, 2, 3, w);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("t6_rst_mem_address", 32'(mem_address), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    check("t6_rst_pix_valid", 32'(pix_valid), 32'd0);
    check("t6_rst_pix_data", 32'(pix_data), 32'd0);
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t6_no_stale", 32'(pix_valid), 32'd0);
      @(posedge clock);
      #1;
    end
    issue(2, 3, 1, w);
    req_valid = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
